// File: rtl/rv_pkg.sv
// Shared RV32I constants for the writeback stage: widths, load funct3 codes
// and the per-cycle write-port grant type.
package rv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_LD,
    GNT_ALU
  } grant_e;

endpackage

// File: rtl/writeback_unit_if.sv
// Writeback-stage bus: load issue, ALU and load-response handshakes,
// register-file write port and the pending-load scoreboard.
interface writeback_unit_if;
  import rv_pkg::*;

  logic                  ld_issue;
  logic [REG_ADDR_W-1:0] ld_issue_rd;

  logic                  alu_valid;
  logic                  alu_ready;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_result;

  logic                  ld_valid;
  logic                  ld_ready;
  logic [REG_ADDR_W-1:0] ld_rd;
  logic [2:0]            ld_funct3;
  logic [1:0]            ld_addr_lo;
  logic [XLEN-1:0]       ld_rdata;

  logic                  we;
  logic [REG_ADDR_W-1:0] rd;
  logic [XLEN-1:0]       wd;
  logic [XLEN-1:0]       busy;

  modport master (
    output ld_issue, ld_issue_rd,
    output alu_valid, alu_rd, alu_result,
    output ld_valid, ld_rd, ld_funct3, ld_addr_lo, ld_rdata,
    input  alu_ready, ld_ready,
    input  we, rd, wd, busy
  );

  modport slave (
    input  ld_issue, ld_issue_rd,
    input  alu_valid, alu_rd, alu_result,
    input  ld_valid, ld_rd, ld_funct3, ld_addr_lo, ld_rdata,
    output alu_ready, ld_ready,
    output we, rd, wd, busy
  );

endinterface

// File: rtl/writeback_unit_load_align.sv
// Load data alignment: shifts the raw memory word down by the byte offset,
// then sign- or zero-extends according to the load type.
module load_align
  import rv_pkg::*;
(
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr_lo,
  input  logic [XLEN-1:0] i_rdata,
  output logic [XLEN-1:0] o_data
);

  logic [XLEN-1:0] w_shift;

  always_comb begin
    // Logical shift: bytes vacated by a misaligned access read as zero.
    w_shift = i_rdata >> {i_addr_lo, 3'b000};
    o_data  = w_shift;
    case (i_funct3)
      F3_LB:   o_data = {{24{w_shift[7]}}, w_shift[7:0]};
      F3_LBU:  o_data = {24'h000000, w_shift[7:0]};
      F3_LH:   o_data = {{16{w_shift[15]}}, w_shift[15:0]};
      F3_LHU:  o_data = {16'h0000, w_shift[15:0]};
      F3_LW:   o_data = w_shift;
      default: o_data = w_shift;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: arbitrates ALU results and load responses onto one
// registered register-file write per cycle, with a pending-load scoreboard.
module writeback_unit
  import rv_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  writeback_unit_if.slave  bus
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]      r_starve_cnt;
  logic [XLEN-1:0]       r_busy;
  logic                  r_we;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [XLEN-1:0]       r_wd;

  grant_e                w_grant;
  logic                  w_alu_unblocked;
  logic                  w_alu_force;
  logic [XLEN-1:0]       w_ld_data;
  logic [XLEN-1:0]       w_busy_next;
  logic [REG_ADDR_W-1:0] w_rd_next;
  logic [XLEN-1:0]       w_wd_next;

  load_align u_load_align (
    .i_funct3  (bus.ld_funct3),
    .i_addr_lo (bus.ld_addr_lo),
    .i_rdata   (bus.ld_rdata),
    .o_data    (w_ld_data)
  );

  always_comb begin
    w_alu_unblocked = !r_busy[bus.alu_rd];
    w_alu_force     = bus.alu_valid && w_alu_unblocked && (r_starve_cnt == LIMIT);
    w_grant         = GNT_NONE;
    if (bus.ld_valid && !w_alu_force)
      w_grant = GNT_LD;
    else if (bus.alu_valid && w_alu_unblocked)
      w_grant = GNT_ALU;
  end

  assign bus.ld_ready  = (w_grant == GNT_LD);
  assign bus.alu_ready = (w_grant == GNT_ALU);

  always_comb begin
    w_rd_next = bus.alu_rd;
    w_wd_next = bus.alu_result;
    if (w_grant == GNT_LD) begin
      w_rd_next = bus.ld_rd;
      w_wd_next = w_ld_data;
    end
  end

  // Clear before set so a same-cycle issue to the retiring register stays pending.
  always_comb begin
    w_busy_next = r_busy;
    if (w_grant == GNT_LD)
      w_busy_next[bus.ld_rd] = 1'b0;
    if (bus.ld_issue)
      w_busy_next[bus.ld_issue_rd] = 1'b1;
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (!bus.alu_valid || (w_grant == GNT_ALU)) begin
      r_starve_cnt <= '0;
    end else if ((w_grant == GNT_LD) && w_alu_unblocked && (r_starve_cnt != LIMIT)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we <= 1'b0;
      r_rd <= '0;
      r_wd <= '0;
    end else if (w_grant != GNT_NONE) begin
      r_we <= (w_rd_next != '0);
      r_rd <= w_rd_next;
      r_wd <= w_wd_next;
    end else begin
      r_we <= 1'b0;
    end
  end

  assign bus.we   = r_we;
  assign bus.rd   = r_rd;
  assign bus.wd   = r_wd;
  assign bus.busy = r_busy;

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios plus random
// traffic compared against a behavioural model of grants, writes and scoreboard.
module tb_writeback_unit;

  localparam int LIMIT = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  writeback_unit_if bus ();

  writeback_unit #(.STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  bit          m_busy [32];
  int          m_starve;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_align(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] data);
    longint s;
    longint v;
    s = longint'(data) / (64'd1 << (8 * int'(off)));
    case (f3)
      3'b000: begin v = s % 256;   if (v >= 128)   v = v - 256;   end
      3'b100: v = s % 256;
      3'b001: begin v = s % 65536; if (v >= 32768) v = v - 65536; end
      3'b101: v = s % 65536;
      default: v = s;
    endcase
    return 32'(v);
  endfunction

  function automatic logic [31:0] model_busy_vec();
    logic [31:0] b;
    for (int i = 0; i < 32; i++) b[i] = m_busy[i];
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_starve = 0;
    m_we = 1'b0;
    m_rd = '0;
    m_wd = '0;
  endtask

  task automatic drive_idle();
    bus.ld_issue    = 1'b0;
    bus.ld_issue_rd = '0;
    bus.alu_valid   = 1'b0;
    bus.alu_rd      = '0;
    bus.alu_result  = '0;
    bus.ld_valid    = 1'b0;
    bus.ld_rd       = '0;
    bus.ld_funct3   = '0;
    bus.ld_addr_lo  = '0;
    bus.ld_rdata    = '0;
  endtask

  // One cycle, entered and left at a negedge: drive, check readies, clock, check writes.
  task automatic step(input logic iss, input logic [4:0] iss_rd,
                      input logic av, input logic [4:0] ard, input logic [31:0] ares,
                      input logic lv, input logic [4:0] lrd, input logic [2:0] f3,
                      input logic [1:0] alo, input logic [31:0] ldat,
                      output logic got_alu, output logic got_ld);
    bit e_ld;
    bit e_alu;
    bit alu_free;
    bus.ld_issue    = iss;
    bus.ld_issue_rd = iss_rd;
    bus.alu_valid   = av;
    bus.alu_rd      = ard;
    bus.alu_result  = ares;
    bus.ld_valid    = lv;
    bus.ld_rd       = lrd;
    bus.ld_funct3   = f3;
    bus.ld_addr_lo  = alo;
    bus.ld_rdata    = ldat;
    #1;
    alu_free = av && !m_busy[ard];
    e_ld  = lv && !(alu_free && m_starve == LIMIT);
    e_alu = alu_free && !e_ld;
    got_alu = bus.alu_ready;
    got_ld  = bus.ld_ready;
    check("ld_ready", 32'(bus.ld_ready), 32'(e_ld));
    check("alu_ready", 32'(bus.alu_ready), 32'(e_alu));

    if (!av || e_alu)                             m_starve = 0;
    else if (e_ld && alu_free && m_starve < LIMIT) m_starve = m_starve + 1;

    if (e_ld) begin
      m_we = (lrd != 0); m_rd = lrd; m_wd = ref_align(f3, alo, ldat);
    end else if (e_alu) begin
      m_we = (ard != 0); m_rd = ard; m_wd = ares;
    end else begin
      m_we = 1'b0;
    end
    if (e_ld) m_busy[lrd] = 1'b0;
    if (iss && iss_rd != 0) m_busy[iss_rd] = 1'b1;

    @(posedge clk);
    @(negedge clk);
    check("we", 32'(bus.we), 32'(m_we));
    check("rd", 32'(bus.rd), 32'(m_rd));
    check("wd", bus.wd, m_wd);
    check("busy", bus.busy, model_busy_vec());
  endtask

  task automatic idle_step();
    logic ga, gl;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gl);
  endtask

  task automatic ld_only(input logic [4:0] lrd, input logic [2:0] f3, input logic [1:0] alo,
                         input logic [31:0] ldat);
    logic ga, gl;
    step(0, 0, 0, 0, 0, 1, lrd, f3, alo, ldat, ga, gl);
  endtask

  initial begin
    logic        ga, gl;
    logic [31:0] ldw;
    string       pattern;
    n_checks = 0;
    n_errors = 0;
    model_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_we", 32'(bus.we), 32'h0);
    check("rst_rd", 32'(bus.rd), 32'h0);
    check("rst_wd", bus.wd, 32'h0);
    check("rst_busy", bus.busy, 32'h0);
    rst_n = 1'b1;

    // Load alignment with a fixed word
    ldw = 32'h8899AABB;
    ld_only(5'd10, 3'b000, 2'd1, ldw); check("lb_off1", bus.wd, 32'hFFFFFFAA);
    ld_only(5'd10, 3'b100, 2'd3, ldw); check("lbu_off3", bus.wd, 32'h00000088);
    ld_only(5'd10, 3'b001, 2'd2, ldw); check("lh_off2", bus.wd, 32'hFFFF8899);
    ld_only(5'd10, 3'b101, 2'd0, ldw); check("lhu_off0", bus.wd, 32'h0000AABB);
    ld_only(5'd10, 3'b010, 2'd0, ldw); check("lw", bus.wd, 32'h8899AABB);

    // Same-cycle arbitration: load first, ALU next, back-to-back writes
    step(0, 0, 1, 5'd5, 32'h11, 1, 5'd6, 3'b010, 2'd0, 32'h12345678, ga, gl);
    check("arb_ld_first", 32'(gl), 32'h1);
    check("arb_rd_ld", 32'(bus.rd), 32'd6);
    step(0, 0, 1, 5'd5, 32'h11, 0, 0, 0, 0, 0, ga, gl);
    check("arb_alu_next", 32'(ga), 32'h1);
    check("arb_we2", 32'(bus.we), 32'h1);
    check("arb_wd_alu", bus.wd, 32'h11);

    // Starvation: four load grants, then the ALU, then loads again
    idle_step();
    pattern = "";
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1, 5'd5, 32'h55, 1, 5'd6, 3'b010, 2'd0, 32'(i), ga, gl);
      pattern = {pattern, ga ? "A" : (gl ? "L" : "-")};
      check($sformatf("starve_alu%0d", i), 32'(ga), (i == 4) ? 32'h1 : 32'h0);
    end
    idle_step();

    // WAW: ALU to x7 held off until the x7 load retires
    step(1, 5'd7, 0, 0, 0, 0, 0, 0, 0, 0, ga, gl);
    check("waw_busy7", bus.busy, 32'h00000080);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 5'd7, 32'hDEAD, 0, 0, 0, 0, 0, ga, gl);
      check("waw_blocked", 32'(ga), 32'h0);
    end
    step(0, 0, 1, 5'd7, 32'hDEAD, 1, 5'd7, 3'b010, 2'd0, 32'hCAFE0001, ga, gl);
    check("waw_ld_wd", bus.wd, 32'hCAFE0001);
    check("waw_busy_clr", bus.busy, 32'h0);
    step(0, 0, 1, 5'd7, 32'hDEAD, 0, 0, 0, 0, 0, ga, gl);
    check("waw_alu_go", 32'(ga), 32'h1);
    check("waw_alu_wd", bus.wd, 32'h0000DEAD);

    // x0 handling
    step(0, 0, 1, 5'd0, 32'hFFFF, 0, 0, 0, 0, 0, ga, gl);
    check("x0_alu_ready", 32'(ga), 32'h1);
    check("x0_we", 32'(bus.we), 32'h0);
    step(1, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gl);
    check("x0_busy", bus.busy, 32'h0);

    // Reset mid-stream with a write in flight and a load pending
    step(1, 5'd9, 0, 0, 0, 1, 5'd3, 3'b010, 2'd0, 32'hA5A5A5A5, ga, gl);
    check("pre_rst_we", 32'(bus.we), 32'h1);
    drive_idle();
    rst_n = 1'b0;
    #1;
    check("async_rst_we", 32'(bus.we), 32'h0);
    check("async_rst_busy", bus.busy, 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_step();
    idle_step();

    // Random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      logic       iss, av, lv;
      logic [4:0] iss_rd, ard, lrd;
      int         pend [$];
      pend.delete();
      for (int r = 1; r < 32; r++) if (m_busy[r]) pend.push_back(r);
      iss    = ($urandom_range(0, 9) < 3);
      iss_rd = 5'($urandom_range(0, 15));
      if (iss_rd != 0 && m_busy[iss_rd]) iss = 1'b0;
      av  = ($urandom_range(0, 9) < 6);
      ard = 5'($urandom_range(0, 15));
      lv  = ($urandom_range(0, 9) < (pend.size() > 0 ? 6 : 2));
      if (pend.size() > 0 && $urandom_range(0, 4) != 0)
        lrd = 5'(pend[$urandom_range(0, pend.size() - 1)]);
      else
        lrd = 5'($urandom_range(0, 31));
      step(iss, iss_rd, av, ard, $urandom(), lv, lrd, 3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), $urandom(), ga, gl);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Final pipeline stage of the RV32I core and the sole driver of the register file write port. It accepts completed ALU results and load responses, aligns and sign-extends load data, and arbitrates the two sources onto one registered write per cycle. It also keeps a pending-load scoreboard that blocks ALU writes to registers with an outstanding load (write-after-write protection).

## Interface
Parameters:
- STARVE_LIMIT, 4, maximum consecutive load grants while an ALU result waits before the ALU is forced through (1..15)

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- ld_issue  in  1  load issued to memory this cycle
- ld_issue_rd  in  5  destination of issued load
- alu_valid  in  1  ALU result available
- alu_ready  out  1  ALU result accepted this cycle (combinational)
- alu_rd  in  5  ALU destination register
- alu_result  in  32  ALU result
- ld_valid  in  1  load response available
- ld_ready  out  1  load response accepted this cycle (combinational)
- ld_rd  in  5  load destination register
- ld_funct3  in  3  load type (LB/LH/LW/LBU/LHU encoding)
- ld_addr_lo  in  2  byte offset of load address
- ld_rdata  in  32  raw memory word
- we  out  1  register file write enable (registered)
- rd  out  5  register file destination (registered)
- wd  out  32  register file write data (registered)
- busy  out  32  scoreboard; bit r = load pending to xr; bit 0 always 0

## Operation
- Transfers: a source transfers when valid && ready; at most one transfer per cycle.
- Grant rules, in priority order:
  - ld_valid → ld_ready=1. Exception: if alu_valid, the ALU is unblocked, and starve_cnt == STARVE_LIMIT, the ALU wins instead.
  - Otherwise alu_ready = alu_valid && !busy[alu_rd].
  - An ALU result targeting a busy register is held off (alu_ready=0) until that bit clears.
- starve_cnt: counts load grants while the ALU is waiting and unblocked. Clears on any ALU grant or when alu_valid=0. Saturates at STARVE_LIMIT.
- Load alignment: s = ld_rdata >> (8*ld_addr_lo), logical shift.
  - 000 LB: sign-extend s[7:0]; 100 LBU: zero-extend s[7:0].
  - 001 LH: sign-extend s[15:0]; 101 LHU: zero-extend s[15:0].
  - 010 LW and all other codes: s.
  - Misaligned halfword/word loads are not trapped. Vacated bytes come from the shift (zero).
- Write stage: on a transfer, the next cycle presents we = (dest != 0), rd = dest, wd = data. Otherwise we=0, and rd/wd hold their previous values.
- Scoreboard:
  - ld_issue with ld_issue_rd != 0 sets busy[ld_issue_rd].
  - An accepted load response clears busy[ld_rd] in the same edge.
  - Set and clear of the same register in the same cycle: set wins.
  - Issuing to an already-busy register is illegal upstream; the bit simply stays set.
- Reset mid-operation discards any in-flight write: we drops immediately, and busy clears.

## Timing
- Reset values: we=0, rd=0, wd=0, busy=0, starve_cnt=0. alu_ready/ld_ready follow their combinational equations.
- Latency: handshake in cycle N → we/rd/wd valid in cycle N+1, visible to register file reads in N+2.
- Throughput: one write per cycle, sustained.
- A busy bit set by ld_issue in cycle N blocks ALU writes to that register from cycle N+1.
- A load accepted in cycle N frees its register for ALU grant in cycle N+1.

## Structure
- rv_pkg: localparams for load funct3 codes (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU), plus XLEN=32 and REG_ADDR_W=5.
- Sub-module load_align: purely combinational; inputs funct3, addr_lo, rdata; output aligned 32-bit value.
- writeback_unit contains the arbiter, starvation counter, scoreboard and output register.

## Test plan
- Reset check: assert rst_n=0 mid-stream with we=1 → we=0 and busy=0 asynchronously; no write after release until a new transfer.
- Load alignment, with ld_rdata=0x8899AABB:
  - LB, offset 1 → wd=0xFFFFFFAA
  - LBU, offset 3 → 0x00000088
  - LH, offset 2 → 0xFFFF8899
  - LHU, offset 0 → 0x0000AABB
  - LW → 0x8899AABB
- Same-cycle arbitration: alu_valid (x5=0x11) and ld_valid (x6) together → load written first, ALU written next cycle; two consecutive we pulses.
- Starvation with STARVE_LIMIT=4: ld_valid held high and alu_valid high → four load grants, then one ALU grant, then loads resume.
- WAW block: ld_issue x7; then alu_valid to x7 with 0xDEAD → alu_ready=0 until the load response for x7 is accepted; load data written first, then 0xDEAD the cycle after.
- x0 handling: ALU transfer to x0 → alu_ready=1, we stays 0. ld_issue to x0 → busy stays 0.
